// File: rtl/escalonador_pkg.sv
// escalonador_pkg
// Shared definitions for the active-node scheduler slice:
//   - default parameter values for the scheduler and its interface
//   - FSM state encoding (3-bit localparams, kept numeric for legacy tools)
//   - criterio_lsb(): bit offset of slot i inside the packed criterion bus
package escalonador_pkg;

    localparam int NUM_NA_PADRAO         = 8;
    localparam int CRITERIO_WIDTH_PADRAO = 5;
    localparam int IDX_WIDTH_PADRAO      = 3;
    localparam int TIMEOUT_CICLOS_PADRAO = 12;

    localparam logic [2:0] EST_OCIOSO  = 3'd0;
    localparam logic [2:0] EST_DISPARO = 3'd1;
    localparam logic [2:0] EST_ESPERA  = 3'd2;
    localparam logic [2:0] EST_BUSCA   = 3'd3;
    localparam logic [2:0] EST_OFERTA  = 3'd4;

    // Slot i of a packed criterion bus occupies [largura*i +: largura].
    function automatic int criterio_lsb(input int slot, input int largura);
        return slot * largura;
    endfunction

endpackage

// File: rtl/escalonador_if.sv
// escalonador_if
// Selection handshake between the scheduler (master) and the expansion
// stage (slave).
//   sel_valid_out     master -> slave  selection offered
//   sel_ack_in        slave -> master  accept, effective with sel_valid_out
//   sel_idx_out       master -> slave  chosen slot index
//   sel_onehot_out    master -> slave  chosen slot, one-hot (zero when empty)
//   sel_criterio_out  master -> slave  criterion of chosen slot
//   sel_vazio_out     master -> slave  no active node / no match
interface escalonador_if
    import escalonador_pkg::*;
#(
    parameter int NUM_NA         = NUM_NA_PADRAO,
    parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_PADRAO,
    parameter int IDX_WIDTH      = IDX_WIDTH_PADRAO
);

    logic                      sel_valid_out;
    logic                      sel_ack_in;
    logic [IDX_WIDTH-1:0]      sel_idx_out;
    logic [NUM_NA-1:0]         sel_onehot_out;
    logic [CRITERIO_WIDTH-1:0] sel_criterio_out;
    logic                      sel_vazio_out;

    modport master (
        output sel_valid_out, sel_idx_out, sel_onehot_out, sel_criterio_out, sel_vazio_out,
        input  sel_ack_in
    );

    modport slave (
        input  sel_valid_out, sel_idx_out, sel_onehot_out, sel_criterio_out, sel_vazio_out,
        output sel_ack_in
    );

endinterface

// File: rtl/escalonador_busca_ptr.sv
// escalonador_busca_ptr
// Scan pointer for the BUSCA phase of escalonador_ativo.
// Optional feature macro: ESCALONADOR_RR_EN (round-robin scan start).
//   clk, rst_n      clock, asynchronous active-low reset
//   iniciar         load the start slot for a new scan
//   avancar         move to the next slot
//   confirmar       a non-empty selection was accepted (round-robin only)
//   idx_confirmado  index of that selection
//   ptr             slot currently examined
//   fim             ptr is the last slot of this scan
module escalonador_busca_ptr
    import escalonador_pkg::*;
#(
    parameter int NUM_NA    = NUM_NA_PADRAO,
    parameter int IDX_WIDTH = IDX_WIDTH_PADRAO
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iniciar,
    input  logic                 avancar,
    input  logic                 confirmar,
    input  logic [IDX_WIDTH-1:0] idx_confirmado,
    output logic [IDX_WIDTH-1:0] ptr,
    output logic                 fim
);

    localparam logic [IDX_WIDTH-1:0] ULTIMO_SLOT = IDX_WIDTH'(NUM_NA - 1);

`ifdef ESCALONADOR_RR_EN
    logic [IDX_WIDTH-1:0] ultimo_idx;
    logic [IDX_WIDTH-1:0] examinados;

    function automatic logic [IDX_WIDTH-1:0] proximo(input logic [IDX_WIDTH-1:0] p);
        return (p == ULTIMO_SLOT) ? '0 : p + 1'b1;
    endfunction

    // The pointer wraps, so the end of the scan is tracked by a separate
    // count of slots already examined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            examinados <= '0;
            ultimo_idx <= '0;
        end else begin
            if (iniciar) begin
                ptr        <= proximo(ultimo_idx);
                examinados <= '0;
            end else if (avancar) begin
                ptr        <= proximo(ptr);
                examinados <= examinados + 1'b1;
            end
            if (confirmar) begin
                ultimo_idx <= idx_confirmado;
            end
        end
    end

    assign fim = (examinados == ULTIMO_SLOT);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (iniciar) begin
            ptr <= '0;
        end else if (avancar) begin
            ptr <= ptr + 1'b1;
        end
    end

    assign fim = (ptr == ULTIMO_SLOT);

    // Acceptance feedback only matters for the round-robin start.
    logic unused_confirmacao;
    assign unused_confirmacao = ^{confirmar, idx_confirmado};
`endif

endmodule

// File: rtl/escalonador_ativo.sv
// escalonador_ativo
// Sequencer for the active-node minimum classifier: snapshots the active
// mask on request, pulses the classifier, waits for its result, scans for the
// first active slot whose criterion equals the returned minimum and offers it
// on a valid/ack handshake.
// Optional feature macro: ESCALONADOR_RR_EN (round-robin tie rotation, in
// escalonador_busca_ptr).
//   clk, rst_n            clock, asynchronous active-low reset
//   req_in                start a selection (sampled only when idle)
//   na_ativo_in           active mask, snapshotted at request
//   na_criterio_in        packed criteria, stable while ocupado_out
//   ca_atualizar_out      one-cycle update pulse to classifier
//   ca_pronto_in          classifier done (level)
//   ca_criterio_geral_in  classifier minimum
//   sel                   selection handshake (escalonador_if.master)
//   ocupado_out           sequencer not idle
//   erro_out              sticky fault (timeout / no match), cleared by next request
module escalonador_ativo
    import escalonador_pkg::*;
#(
    parameter int NUM_NA         = NUM_NA_PADRAO,
    parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_PADRAO,
    parameter int IDX_WIDTH      = IDX_WIDTH_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
)
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_in,
    input  logic [NUM_NA-1:0]                na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
    output logic                             ca_atualizar_out,
    input  logic                             ca_pronto_in,
    input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
    escalonador_if.master                    sel,
    output logic                             ocupado_out,
    output logic                             erro_out
);

    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] ESPERA_MAX = TW'(TIMEOUT_CICLOS - 1);

    logic [2:0]                estado;
    logic [NUM_NA-1:0]         mascara;
    logic [CRITERIO_WIDTH-1:0] minimo;
    logic [TW-1:0]             espera_cnt;

    logic [IDX_WIDTH-1:0]      idx_q;
    logic [NUM_NA-1:0]         onehot_q;
    logic [CRITERIO_WIDTH-1:0] criterio_q;
    logic                      vazio_q;

    logic [IDX_WIDTH-1:0]      ptr;
    logic                      fim;
    logic                      acerto;
    logic                      pronto_valido;
    logic                      aceito;

    logic [CRITERIO_WIDTH-1:0] criterio_slot [NUM_NA];

    for (genvar g = 0; g < NUM_NA; g++) begin : g_slot
        assign criterio_slot[g] = na_criterio_in[criterio_lsb(g, CRITERIO_WIDTH) +: CRITERIO_WIDTH];
    end

    // The classifier drops ca_pronto_in one edge after the pulse, so the
    // first ESPERA cycle (counter still 0) sees a stale flag and is skipped.
    assign pronto_valido = (estado == EST_ESPERA) && (espera_cnt != '0) && ca_pronto_in;
    assign acerto        = mascara[ptr] && (criterio_slot[ptr] == minimo);
    assign aceito        = (estado == EST_OFERTA) && sel.sel_ack_in;

    escalonador_busca_ptr #(
        .NUM_NA    (NUM_NA),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_busca_ptr (
        .clk            (clk),
        .rst_n          (rst_n),
        .iniciar        (pronto_valido),
        .avancar        ((estado == EST_BUSCA) && !acerto && !fim),
        .confirmar      (aceito && !vazio_q),
        .idx_confirmado (idx_q),
        .ptr            (ptr),
        .fim            (fim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= EST_OCIOSO;
            mascara    <= '0;
            minimo     <= '0;
            espera_cnt <= '0;
            idx_q      <= '0;
            onehot_q   <= '0;
            criterio_q <= '0;
            vazio_q    <= 1'b0;
            erro_out   <= 1'b0;
        end else begin
            case (estado)
                EST_OCIOSO: begin
                    if (req_in) begin
                        mascara  <= na_ativo_in;
                        erro_out <= 1'b0;
                        if (na_ativo_in == '0) begin
                            // Nothing active: answer empty without bothering the classifier.
                            idx_q      <= '0;
                            onehot_q   <= '0;
                            criterio_q <= '0;
                            vazio_q    <= 1'b1;
                            estado     <= EST_OFERTA;
                        end else begin
                            estado <= EST_DISPARO;
                        end
                    end
                end
                EST_DISPARO: begin
                    espera_cnt <= '0;
                    estado     <= EST_ESPERA;
                end
                EST_ESPERA: begin
                    if (pronto_valido) begin
                        minimo <= ca_criterio_geral_in;
                        estado <= EST_BUSCA;
                    end else if (espera_cnt == ESPERA_MAX) begin
                        erro_out   <= 1'b1;
                        idx_q      <= '0;
                        onehot_q   <= '0;
                        criterio_q <= '0;
                        vazio_q    <= 1'b1;
                        estado     <= EST_OFERTA;
                    end else begin
                        espera_cnt <= espera_cnt + 1'b1;
                    end
                end
                EST_BUSCA: begin
                    if (acerto) begin
                        idx_q      <= ptr;
                        onehot_q   <= NUM_NA'(1) << ptr;
                        criterio_q <= criterio_slot[ptr];
                        vazio_q    <= 1'b0;
                        estado     <= EST_OFERTA;
                    end else if (fim) begin
                        // Minimum came from an inactive seed slot: no active match.
                        erro_out   <= 1'b1;
                        idx_q      <= '0;
                        onehot_q   <= '0;
                        criterio_q <= '0;
                        vazio_q    <= 1'b1;
                        estado     <= EST_OFERTA;
                    end
                end
                EST_OFERTA: begin
                    if (sel.sel_ack_in) begin
                        estado <= EST_OCIOSO;
                    end
                end
                default: begin
                    estado <= EST_OCIOSO;
                end
            endcase
        end
    end

    assign ca_atualizar_out     = (estado == EST_DISPARO);
    assign ocupado_out          = (estado != EST_OCIOSO);
    assign sel.sel_valid_out    = (estado == EST_OFERTA);
    assign sel.sel_idx_out      = idx_q;
    assign sel.sel_onehot_out   = onehot_q;
    assign sel.sel_criterio_out = criterio_q;
    assign sel.sel_vazio_out    = vazio_q;

endmodule

// File: tb/tb_escalonador_ativo.sv
// tb_escalonador_ativo
// Self-checking bench for escalonador_ativo with a behavioural classifier
// (NUM_NA-cycle latency, minimum seeded from slot 0) and a reference model of
// the expected selection, latency and fault flag.
module tb_escalonador_ativo;

    localparam int N  = 8;
    localparam int W  = 5;
    localparam int IW = 3;
    localparam int TO = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_in = 1'b0;
    logic [N-1:0]   na_ativo_in = '0;
    logic [N*W-1:0] na_criterio_in = '0;
    logic           ca_atualizar_out;
    logic           ca_pronto_in;
    logic [W-1:0]   ca_criterio_geral_in;
    logic           ocupado_out;
    logic           erro_out;

    escalonador_if #(.NUM_NA(N), .CRITERIO_WIDTH(W), .IDX_WIDTH(IW)) sel_if ();

    escalonador_ativo #(
        .NUM_NA         (N),
        .CRITERIO_WIDTH (W),
        .IDX_WIDTH      (IW),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_in               (req_in),
        .na_ativo_in          (na_ativo_in),
        .na_criterio_in       (na_criterio_in),
        .ca_atualizar_out     (ca_atualizar_out),
        .ca_pronto_in         (ca_pronto_in),
        .ca_criterio_geral_in (ca_criterio_geral_in),
        .sel                  (sel_if),
        .ocupado_out          (ocupado_out),
        .erro_out             (erro_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_pulsos = 0;
    bit cls_mudo = 1'b0;
    int cls_cnt;
    int ref_ultimo = 0;

    function automatic logic [W-1:0] slot(input logic [N*W-1:0] c, input int i);
        logic [N*W-1:0] t;
        t = c >> (W * i);
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] minimo_ref(input logic [N-1:0] m, input logic [N*W-1:0] c);
        logic [W-1:0] v;
        v = slot(c, 0);
        for (int i = 0; i < N; i++)
            if (m[i] && slot(c, i) < v) v = slot(c, i);
        return v;
    endfunction

    // Classifier stand-in: the flag stays stale for one edge after the pulse,
    // drops, and rises NUM_NA edges after the pulse with the minimum.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_pronto_in         <= 1'b1;
            ca_criterio_geral_in <= '0;
            cls_cnt              <= 0;
        end else if (ca_atualizar_out) begin
            cls_cnt <= N;
        end else if (cls_cnt > 0) begin
            cls_cnt      <= cls_cnt - 1;
            ca_pronto_in <= (cls_cnt == 1) && !cls_mudo;
            if (cls_cnt == 1) ca_criterio_geral_in <= minimo_ref(na_ativo_in, na_criterio_in);
        end else if (cls_mudo) begin
            ca_pronto_in <= 1'b0;
        end
    end

    always @(posedge clk) if (ca_atualizar_out === 1'b1) n_pulsos++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic passo();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome of one request, from the selection rules.
    function automatic void modelo(input logic [N-1:0] m, input logic [N*W-1:0] c, input int inicio,
                                   input bit mudo, output bit vazio, output bit erro,
                                   output int idx, output int lat);
        logic [W-1:0] mn;
        vazio = 1'b1; erro = 1'b0; idx = 0; lat = 1;
        if (m == '0) return;
        erro = 1'b1;
        if (mudo) begin
            lat = 2 + TO;
            return;
        end
        mn  = minimo_ref(m, c);
        lat = 2 + (N + 1) + N;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (inicio + k) % N;
            if (m[i] && slot(c, i) == mn) begin
                vazio = 1'b0; erro = 1'b0; idx = i; lat = 2 + (N + 1) + k + 1;
                break;
            end
        end
    endfunction

    task automatic executar(input string nome, input logic [N-1:0] m, input logic [N*W-1:0] c,
                            input int segurar);
        bit e_vazio, e_erro;
        int e_idx, e_lat, lat, p0, inicio;
        logic [N-1:0] e_oh;
        logic [W-1:0] e_crit;
`ifdef ESCALONADOR_RR_EN
        inicio = (ref_ultimo + 1) % N;
`else
        inicio = 0;
`endif
        modelo(m, c, inicio, cls_mudo, e_vazio, e_erro, e_idx, e_lat);
        e_oh   = e_vazio ? '0 : (N'(1) << e_idx);
        e_crit = e_vazio ? '0 : slot(c, e_idx);
        na_ativo_in = m; na_criterio_in = c; req_in = 1'b1; p0 = n_pulsos;
        passo();
        lat = 1; req_in = 1'b0;
        chk({nome, "/erro_limpo"}, erro_out, 0);
        while (sel_if.sel_valid_out !== 1'b1 && lat < 60) begin
            passo();
            lat++;
        end
        chk({nome, "/latencia"}, lat, e_lat);
        chk({nome, "/vazio"}, sel_if.sel_vazio_out, e_vazio);
        chk({nome, "/erro"}, erro_out, e_erro);
        chk({nome, "/idx"}, sel_if.sel_idx_out, e_idx);
        chk({nome, "/onehot"}, sel_if.sel_onehot_out, e_oh);
        chk({nome, "/criterio"}, sel_if.sel_criterio_out, e_crit);
        chk({nome, "/pulsos"}, n_pulsos - p0, (m != '0) ? 1 : 0);
        for (int k = 0; k < segurar; k++) begin
            req_in = ~req_in;
            na_criterio_in = {$urandom, $urandom};
            passo();
            chk({nome, "/segura_valid"}, sel_if.sel_valid_out, 1);
            chk({nome, "/segura_idx"}, sel_if.sel_idx_out, e_idx);
            chk({nome, "/segura_crit"}, sel_if.sel_criterio_out, e_crit);
            chk({nome, "/segura_onehot"}, sel_if.sel_onehot_out, e_oh);
            chk({nome, "/segura_pulsos"}, n_pulsos - p0, (m != '0) ? 1 : 0);
        end
        sel_if.sel_ack_in = 1'b1;
        req_in = (segurar > 0);
        passo();
        sel_if.sel_ack_in = 1'b0;
        req_in = 1'b0;
        chk({nome, "/ocioso"}, ocupado_out, 0);
        if (segurar > 0) begin
            passo();
            chk({nome, "/req_no_ack_ignorado"}, ocupado_out, 0);
        end
        if (!e_vazio) ref_ultimo = e_idx;
    endtask

    initial begin
        logic [N*W-1:0] c;
        sel_if.sel_ack_in = 1'b0;
        repeat (3) passo();

        // Outputs while reset is held, then after release.
        chk("reset/saidas", {ca_atualizar_out, sel_if.sel_valid_out, sel_if.sel_vazio_out,
             sel_if.sel_idx_out, sel_if.sel_onehot_out, sel_if.sel_criterio_out,
             ocupado_out, erro_out}, 0);
        rst_n = 1'b1;
        passo();
        chk("reset/ocupado", ocupado_out, 0);

        // Two minima at slots 1 and 6: rotate under round-robin, stick otherwise.
        c = {N * W{1'b0}};
        for (int i = 0; i < N; i++) c[W*i +: W] = 5'd20;
        c[W*1 +: W] = 5'd2; c[W*6 +: W] = 5'd2; c[W*2 +: W] = 5'd7;
        for (int r = 0; r < 4; r++) executar("empate", 8'b0100_0110, c, 0);

        // Lowest-index tie at the minimum, 15-cycle latency.
        for (int i = 0; i < N; i++) c[W*i +: W] = 5'd31;
        c[W*2 +: W] = 5'd9; c[W*3 +: W] = 5'd4; c[W*5 +: W] = 5'd4;
        executar("basico", 8'b0010_1100, c, 0);

        executar("mascara_vazia", 8'h00, c, 0);

        cls_mudo = 1'b1;
        executar("timeout", 8'b0010_1100, c, 0);
        cls_mudo = 1'b0;
        executar("apos_timeout", 8'b0010_1100, c, 0);

        executar("segura_ack", 8'b1001_0001, c, 5);

        // Reset while waiting for the classifier.
        na_ativo_in = 8'b0000_1010; na_criterio_in = c; req_in = 1'b1;
        passo();
        req_in = 1'b0;
        repeat (4) passo();
        rst_n = 1'b0;
        #1;
        chk("reset_espera/saidas", {ca_atualizar_out, sel_if.sel_valid_out, sel_if.sel_vazio_out,
             sel_if.sel_idx_out, sel_if.sel_onehot_out, sel_if.sel_criterio_out,
             ocupado_out, erro_out}, 0);
        passo();
        rst_n = 1'b1;
        ref_ultimo = 0;
        passo();
        executar("pos_reset", 8'b0000_1010, c, 0);

        // Random masks and criteria; small value range forces ties and no-match cases.
        for (int r = 0; r < 24; r++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) m = '0;
            for (int i = 0; i < N; i++) c[W*i +: W] = W'($urandom_range(0, 5));
            executar("aleatorio", m, c, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
